ps2_key_queue: RTL and testbench
================================

PS2_KEY_QUEUE -- requirements
Module: ps2_key_queue

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of queued key events; power of two, 2..64.
REQ-002 Parameter FILTER_LEN, default 8, number of clk samples of ps2c that must agree before the filtered clock changes.
REQ-003 Parameter TIMEOUT_CYC, default 5000, idle clk cycles with no ps2c falling edge after which a partial frame is abandoned.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 ps2c  input  1  raw PS/2 clock, asynchronous.
REQ-007 ps2d  input  1  raw PS/2 data, asynchronous.
REQ-008 rx_en  input  1  start-bit acceptance enable.
REQ-009 rd_ack  input  1  one-cycle pop strobe from the PicoBlaze port logic.
REQ-010 clr_err  input  1  clears the sticky error flags.
REQ-011 key_code  output  8  scan code of the head event.
REQ-012 key_ext  output  1  head event carried an E0 prefix.
REQ-013 key_brk  output  1  head event is a release (F0 prefix).
REQ-014 key_valid  output  1  queue is non-empty; head fields are valid.
REQ-015 fifo_cnt  output  $clog2(FIFO_DEPTH)+1  number of queued events.
REQ-016 ovf_err  output  1  sticky flag: an event was dropped because the queue was full.
REQ-017 frm_err  output  1  sticky flag: a frame was rejected or timed out.

Function
REQ-018 ps2c SHALL pass through a FILTER_LEN shift register; the filtered clock goes 1 only on all-ones and 0 only on all-zeros; fall_tick fires on its 1->0 transition.
REQ-019 Frame FSM states: IDLE, SHIFT, CHECK.
- IDLE->SHIFT: on fall_tick with rx_en=1, start bit captured, bit counter set to 9.
- SHIFT: on each fall_tick shift ps2d in LSB-first; after 10 more bits go to CHECK.
- CHECK: one cycle, then IDLE; emits byte_tick with the 8 data bits.
REQ-020 In SHIFT, TIMEOUT_CYC clk cycles without fall_tick SHALL return the FSM to IDLE, discard the partial frame, and set frm_err.
REQ-021 Decoder: byte E0 sets ext_pend; byte F0 sets brk_pend; neither prefix enqueues anything.
REQ-022 Any other byte SHALL enqueue {ext_pend, brk_pend, byte} on the clk edge after byte_tick and clear both pend flags on the same edge.
REQ-023 Queue is first-word-fall-through: an event enqueued into an empty queue is visible on key_* with key_valid=1 in the cycle after the enqueue edge.
REQ-024 rd_ack with key_valid=1 SHALL pop the head on that edge; rd_ack with key_valid=0 SHALL be ignored.
REQ-025 Push when full with no pop: event dropped, queue unchanged, ovf_err set.
REQ-026 Simultaneous push and pop when full: both happen; fifo_cnt is unchanged; no ovf_err.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_cnt ranges 0..FIFO_DEPTH.
REQ-028 clr_err clears both sticky flags; if a new error occurs in the same cycle, the set wins.
REQ-029 key_code, key_ext and key_brk SHALL read 0 whenever key_valid=0.

Reset
REQ-030 On reset=0, asynchronously: FSM to IDLE; filter, pend flags, pointers, fifo_cnt, ovf_err, frm_err and all outputs to 0.
REQ-031 A reset in the middle of a frame SHALL discard the partial frame; the next frame is accepted only from a fresh start bit.

Configuration
REQ-032 Macro PS2_PARITY_CHK_EN.
- Defined: CHECK rejects the frame if odd parity fails, the stop bit is 0, or the start bit is 1; a rejected frame emits no byte_tick and sets frm_err.
- Undefined: parity and framing bits are ignored; frm_err is set only by timeout.

Structure
REQ-033 Package ps2_pkg SHALL hold the FSM state enum, the PS2_EXT_PREFIX=8'hE0 and PS2_BRK_PREFIX=8'hF0 constants, and a 10-bit key-event struct type.
REQ-034 Filter plus frame FSM SHALL be sub-module ps2_rx_frame (outputs byte_tick, byte_data, frame_err); decoder and queue stay in ps2_key_queue.

Verification
REQ-035 Send frame 0x1C with good parity -> key_valid=1, key_code=0x1C, key_ext=0, key_brk=0, fifo_cnt=1.
REQ-036 Send E0,F0,75 -> exactly one event {ext=1, brk=1, code=0x75}; rd_ack -> key_valid=0, all key_* read 0.
REQ-037 With FIFO_DEPTH=8, send 9 make codes without rd_ack -> fifo_cnt=8, ovf_err=1, head equals the first code; the ninth code is lost.
REQ-038 Full queue, rd_ack pulsed in the same cycle as a push -> fifo_cnt stays 8, ovf_err=0, order preserved.
REQ-039 Stop ps2c after 5 bits, wait TIMEOUT_CYC+2 cycles -> frm_err=1, FSM in IDLE; then send 0x5A -> event 0x5A queued.
REQ-040 With PS2_PARITY_CHK_EN, send 0x2B with flipped parity -> no event, frm_err=1; assert reset=0 mid-frame -> all outputs 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and scan-code prefix constants for the PS/2 key queue.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} rx_state_t;
    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_evt_t;
endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 clock glitch filter and 11-bit frame receiver.
// PS2_PARITY_CHK_EN enables start/parity/stop validation of each frame.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic       byte_tick,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [FILTER_LEN-1:0] filt;
    logic                  f_clk;
    logic [1:0]            d_sync;
    logic [10:0]           sr;
    logic [3:0]            bit_cnt;
    logic [TW-1:0]         tmr;
    logic                  fall_tick;
    logic                  frame_ok;
    rx_state_t             state;

    // filtered clock is about to drop: current high, window all zeros
    assign fall_tick = f_clk & ~|filt;

`ifdef PS2_PARITY_CHK_EN
    assign frame_ok = (^sr[9:1]) & sr[10] & ~sr[0];
`else
    logic unused_framing;
    assign unused_framing = ^{sr[10:9], sr[0]};
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt   <= '0;
            f_clk  <= 1'b0;
            d_sync <= '0;
        end else begin
            filt   <= {filt[FILTER_LEN-2:0], ps2c};
            f_clk  <= &filt ? 1'b1 : (~|filt ? 1'b0 : f_clk);
            d_sync <= {d_sync[0], ps2d};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            tmr       <= '0;
            byte_tick <= 1'b0;
            byte_data <= '0;
            frame_err <= 1'b0;
        end else begin
            byte_tick <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: if (fall_tick && rx_en) begin
                    sr      <= {d_sync[1], sr[10:1]};
                    bit_cnt <= 4'd9;
                    tmr     <= '0;
                    state   <= SHIFT;
                end
                SHIFT: if (fall_tick) begin
                    sr      <= {d_sync[1], sr[10:1]};
                    bit_cnt <= bit_cnt - 4'd1;
                    tmr     <= '0;
                    if (bit_cnt == 4'd0) state <= CHECK;
                end else if (tmr == TW'(TIMEOUT_CYC - 1)) begin
                    state     <= IDLE;
                    frame_err <= 1'b1;
                end else begin
                    tmr <= tmr + 1'b1;
                end
                CHECK: begin
                    state     <= IDLE;
                    byte_tick <= frame_ok;
                    frame_err <= ~frame_ok;
                    byte_data <= sr[8:1];
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/ps2_key_queue.sv
// ps2_key_queue: PS/2 scan-code decoder (E0/F0 prefixes) feeding a FWFT key-event queue.
// PS2_PARITY_CHK_EN (in ps2_rx_frame) rejects frames with bad parity/framing.
module ps2_key_queue
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ps2c,
    input  logic                        ps2d,
    input  logic                        rx_en,
    input  logic                        rd_ack,
    input  logic                        clr_err,
    output logic [7:0]                  key_code,
    output logic                        key_ext,
    output logic                        key_brk,
    output logic                        key_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
    output logic                        ovf_err,
    output logic                        frm_err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic          byte_tick;
    logic [7:0]    byte_data;
    logic          frame_err;
    logic          ext_pend, brk_pend;
    logic          is_ext, is_brk, push, pop, full, wr_en, ovf_set;
    logic [AW-1:0] wr_ptr, rd_ptr;
    key_evt_t      mem [FIFO_DEPTH];
    key_evt_t      head;

    ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .rx_en     (rx_en),
        .byte_tick (byte_tick),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    assign is_ext    = byte_data == PS2_EXT_PREFIX;
    assign is_brk    = byte_data == PS2_BRK_PREFIX;
    assign push      = byte_tick & ~is_ext & ~is_brk;
    assign key_valid = fifo_cnt != '0;
    assign pop       = rd_ack & key_valid;
    assign full      = fifo_cnt == (AW + 1)'(FIFO_DEPTH);
    // a pop in the same cycle frees the slot the push needs
    assign wr_en     = push & (~full | pop);
    assign ovf_set   = push & full & ~pop;
    assign head      = key_valid ? mem[rd_ptr] : '0;
    assign {key_ext, key_brk, key_code} = head;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= '{ext: ext_pend, brk: brk_pend, code: byte_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ovf_err  <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            ext_pend <= (byte_tick & is_ext) ? 1'b1 : (push ? 1'b0 : ext_pend);
            brk_pend <= (byte_tick & is_brk) ? 1'b1 : (push ? 1'b0 : brk_pend);
            wr_ptr   <= wr_ptr + AW'(wr_en);
            rd_ptr   <= rd_ptr + AW'(pop);
            fifo_cnt <= fifo_cnt + (AW + 1)'(wr_en) - (AW + 1)'(pop);
            ovf_err  <= ovf_set | (ovf_err & ~clr_err);
            frm_err  <= frame_err | (frm_err & ~clr_err);
        end
    end
endmodule

// File: tb/tb_ps2_key_queue.sv
// tb_ps2_key_queue: randomized PS/2 frame stimulus checked against a queue-based key-event model.
module tb_ps2_key_queue;
    import ps2_pkg::*;

    localparam int TIMEOUT_CYC = 5000;
`ifdef PS2_PARITY_CHK_EN
    localparam bit PARITY_CHK = 1'b1;
`else
    localparam bit PARITY_CHK = 1'b0;
`endif

    logic       clk = 1'b0, reset = 1'b0, ps2c = 1'b1, ps2d = 1'b1;
    logic       rx_en = 1'b0, rd_ack = 1'b0, clr_err = 1'b0;
    logic [7:0] key_code;
    logic       key_ext, key_brk, key_valid, ovf_err, frm_err;
    logic [3:0] fifo_cnt;

    int total = 0, bad = 0;

    // reference model: event list plus pending prefixes and sticky flags
    logic [9:0] mq[$];
    logic       ext_p, brk_p, ovf_m, frm_m;

    ps2_key_queue #(.FIFO_DEPTH(8), .FILTER_LEN(8), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
        .rd_ack(rd_ack), .clr_err(clr_err), .key_code(key_code), .key_ext(key_ext),
        .key_brk(key_brk), .key_valid(key_valid), .fifo_cnt(fifo_cnt),
        .ovf_err(ovf_err), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [9:0] h;
        h = mq.size() != 0 ? mq[0] : 10'h0;
        check({tag, ".valid"}, int'(key_valid), int'(mq.size() != 0));
        check({tag, ".cnt"},   int'(fifo_cnt),  mq.size());
        check({tag, ".code"},  int'(key_code),  int'(h[7:0]));
        check({tag, ".ext"},   int'(key_ext),   int'(h[9]));
        check({tag, ".brk"},   int'(key_brk),   int'(h[8]));
        check({tag, ".ovf"},   int'(ovf_err),   int'(ovf_m));
        check({tag, ".frm"},   int'(frm_err),   int'(frm_m));
    endtask

    task automatic model_reset();
        mq.delete();
        ext_p = 1'b0; brk_p = 1'b0; ovf_m = 1'b0; frm_m = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic flip);
        if (flip && PARITY_CHK) frm_m = 1'b1;
        else if (b == 8'hE0) ext_p = 1'b1;
        else if (b == 8'hF0) brk_p = 1'b1;
        else begin
            if (mq.size() == 8) ovf_m = 1'b1;
            else mq.push_back({ext_p, brk_p, b});
            ext_p = 1'b0; brk_p = 1'b0;
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic flip);
        return {1'b1, (~^b) ^ flip, b, 1'b0};
    endfunction

    task automatic ps2_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2d = f[i];
            repeat (10) @(negedge clk);
            ps2c = 1'b0;
            repeat (20) @(negedge clk);
            ps2c = 1'b1;
            repeat (10) @(negedge clk);
        end
        ps2d = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic flip);
        ps2_bits(frame(b, flip), 11);
        repeat (40) @(negedge clk);
        model_byte(b, flip);
    endtask

    task automatic pop();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
        @(negedge clk);
    endtask

    task automatic clear_err();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        ovf_m = 1'b0; frm_m = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 16 && mq.size() != 0; i++) begin
            check_state(tag);
            pop();
        end
        check_state({tag, ".end"});
    endtask

    initial begin
        logic found;
        int   op;
        model_reset();
        repeat (3) @(negedge clk);
        check_state("reset");
        reset = 1'b1;
        rx_en = 1'b1;
        repeat (20) @(negedge clk);

        send(8'h1C, 1'b0);
        check_state("make_1c");
        check("make_1c.code_lit", int'(key_code), 'h1C);
        pop();
        check_state("pop_1c");
        pop();
        check_state("pop_empty");

        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        check_state("prefix_only");
        send(8'h75, 1'b0);
        check_state("ext_brk_75");
        check("ext_brk_75.cnt_lit", int'(fifo_cnt), 1);
        pop();
        check_state("ext_brk_pop");

        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i), 1'b0);
        check_state("overflow");
        check("overflow.head_lit", int'(key_code), 'h10);
        clear_err();
        check_state("ovf_cleared");

        found = 1'b0;
        fork
            ps2_bits(frame(8'h30, 1'b0), 11);
            begin
                for (int i = 0; i < 2000; i++) begin
                    @(negedge clk);
                    if (dut.byte_tick) begin
                        found = 1'b1;
                        break;
                    end
                end
                rd_ack = found;
                @(negedge clk);
                rd_ack = 1'b0;
            end
        join
        repeat (40) @(negedge clk);
        check("full_rw.tick_seen", int'(found), 1);
        void'(mq.pop_front());
        model_byte(8'h30, 1'b0);
        check_state("full_rw");
        drain("full_rw_order");

        ps2_bits(frame(8'h5A, 1'b0), 5);
        repeat (TIMEOUT_CYC + 2) @(negedge clk);
        frm_m = 1'b1;
        check_state("timeout");
        check("timeout.state", int'(dut.u_rx.state), int'(IDLE));
        clear_err();
        send(8'h5A, 1'b0);
        check_state("after_timeout");
        pop();

        send(8'h2B, 1'b1);
        check_state("bad_parity");
        clear_err();
        drain("parity_drain");

        for (int n = 0; n < 25; n++) begin
            op = int'($urandom_range(0, 7));
            case (op)
                0: send(8'hE0, $urandom_range(0, 7) == 0);
                1: send(8'hF0, $urandom_range(0, 7) == 0);
                2, 3, 4: send(8'($urandom_range(1, 127)), $urandom_range(0, 7) == 0);
                5, 6: pop();
                default: clear_err();
            endcase
            check_state($sformatf("rand%0d", n));
        end

        send(8'h21, 1'b0);
        ps2_bits(frame(8'h66, 1'b0), 4);
        reset = 1'b0;
        #2;
        model_reset();
        check_state("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        send(8'h22, 1'b0);
        check_state("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
